hazard_scoreboard: RTL and testbench

//  Per-register RAW/WAW scoreboard that generates the decode-stage pause.

---
 rtl/hazard_scoreboard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_sb_counter.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 145 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared types and constants for the decode-stage hazard scoreboard.
//   SB_CNT_WIDTH : default width of each per-register in-flight counter
//   sb_cnt_t     : per-register counter type
//   sb_hazard_t  : per-operand hazard flags, kept as a named signal for debug
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int SB_CNT_WIDTH = 2;

    typedef logic [SB_CNT_WIDTH-1:0] sb_cnt_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } sb_hazard_t;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
//   Saturating up/down counter holding the number of in-flight writes to one
//   architectural register.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : issue / retire event for this register (both -> no change)
//   clr        : flush; wins over inc/dec, which are then dropped
//   cnt        : current count
//   ovf        : this cycle's inc was refused because the counter is full
//   unf        : this cycle's dec was refused because the counter is empty
// -----------------------------------------------------------------------------
module sb_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int W = SB_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf,
    output logic         unf
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == MAX) ovf = 1'b1;
            else              cnt_d = cnt_q + W'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) unf = 1'b1;
            else             cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Per-register RAW/WAW scoreboard producing the decode-stage pause.
//   Issue events (dec->exe handshake) increment a register's in-flight count,
//   writeback retire events decrement it; x0 is never tracked.
//
//   Optional feature macro: SCOREBOARD_BYPASS_EN
//     defined   : a same-cycle final retire of a source register (or any
//                 retire of a saturated rd) releases the stall in that cycle,
//                 relying on register-file write-through on read.
//     undefined : pause depends on the registered counts only.
//
//   Ports
//     clk, rst_n         clock, asynchronous active-low reset
//     chk_*              decode-stage instruction being checked
//     iss_fire/rd_addr/rd_we  instruction leaving decode
//     ret_valid/rd_addr  register-file writeback
//     flush              discard all tracking (errors are kept)
//     pause              combinational decode stall
//     inflight_total     registered sum of all counters
//     err_overflow       sticky: issue to a saturated counter
//     err_underflow      sticky: retire of an empty counter
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_NUM        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = SB_CNT_WIDTH,
    parameter int TOT_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      chk_valid,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1_addr,
    input  logic                      chk_rs1_used,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2_addr,
    input  logic                      chk_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rd_addr,
    input  logic                      chk_rd_used,
    input  logic                      iss_fire,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rd_addr,
    input  logic                      iss_rd_we,
    input  logic                      ret_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ret_rd_addr,
    input  logic                      flush,
    output logic                      pause,
    output logic [TOT_WIDTH-1:0]      inflight_total,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_arr [REG_NUM];
    logic [REG_NUM-1:0]   inc_v;
    logic [REG_NUM-1:0]   dec_v;
    logic [REG_NUM-1:0]   ovf_v;
    logic [REG_NUM-1:0]   unf_v;

    // Entry 0 models x0: permanently empty, never counted.
    assign cnt_arr[0] = '0;
    assign inc_v[0]   = 1'b0;
    assign dec_v[0]   = 1'b0;
    assign ovf_v[0]   = 1'b0;
    assign unf_v[0]   = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        assign inc_v[r] = iss_fire && iss_rd_we && (iss_rd_addr == REG_ADDR_WIDTH'(r));
        assign dec_v[r] = ret_valid && (ret_rd_addr == REG_ADDR_WIDTH'(r));

        sb_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_v[r]),
            .dec   (dec_v[r]),
            .clr   (flush),
            .cnt   (cnt_arr[r]),
            .ovf   (ovf_v[r]),
            .unf   (unf_v[r])
        );
    end

    // ---------------- hazard / pause ----------------
    sb_hazard_t           hz;
    logic [CNT_WIDTH-1:0] c_rs1, c_rs2, c_rd;
    logic                 rel_rs1, rel_rs2, rel_rd;

    always_comb begin
        c_rs1 = cnt_arr[chk_rs1_addr];
        c_rs2 = cnt_arr[chk_rs2_addr];
        c_rd  = cnt_arr[chk_rd_addr];
`ifdef SCOREBOARD_BYPASS_EN
        // Only the last outstanding write clears a source hazard early.
        rel_rs1 = ret_valid && (ret_rd_addr == chk_rs1_addr) && (c_rs1 == CNT_ONE);
        rel_rs2 = ret_valid && (ret_rd_addr == chk_rs2_addr) && (c_rs2 == CNT_ONE);
        // Any retire of rd frees a slot, so the overflow guard can relax.
        rel_rd  = ret_valid && (ret_rd_addr == chk_rd_addr);
`else
        rel_rs1 = 1'b0;
        rel_rs2 = 1'b0;
        rel_rd  = 1'b0;
`endif
        hz.rs1 = chk_rs1_used && (chk_rs1_addr != '0) && (c_rs1 != '0) && !rel_rs1;
        hz.rs2 = chk_rs2_used && (chk_rs2_addr != '0) && (c_rs2 != '0) && !rel_rs2;
        hz.rd  = chk_rd_used  && (chk_rd_addr  != '0) && (c_rd == CNT_MAX) && !rel_rd;
        pause  = chk_valid && (hz.rs1 || hz.rs2 || hz.rd);
    end

    // ---------------- total counter ----------------
    // At most one issue and one retire per cycle, so the total moves by at
    // most +/-1; an issue and retire of the same register cancel out.
    logic inc_hit, dec_hit, same_reg, inc_app, dec_app;
    logic [TOT_WIDTH-1:0] total_q, total_d;

    always_comb begin
        inc_hit  = iss_fire && iss_rd_we && (iss_rd_addr != '0);
        dec_hit  = ret_valid && (ret_rd_addr != '0);
        same_reg = inc_hit && dec_hit && (iss_rd_addr == ret_rd_addr);
        inc_app  = inc_hit && !same_reg && !flush && (cnt_arr[iss_rd_addr] != CNT_MAX);
        dec_app  = dec_hit && !same_reg && !flush && (cnt_arr[ret_rd_addr] != '0);
        if (flush) total_d = '0;
        else       total_d = total_q + TOT_WIDTH'(inc_app) - TOT_WIDTH'(dec_app);
    end

    logic ovf_q, unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            ovf_q   <= ovf_q | (|ovf_v);
            unf_q   <= unf_q | (|unf_v);
        end
    end

    assign inflight_total = total_q;
    assign err_overflow   = ovf_q;
    assign err_underflow  = unf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       chk_valid;
    logic [4:0] chk_rs1_addr, chk_rs2_addr, chk_rd_addr;
    logic       chk_rs1_used, chk_rs2_used, chk_rd_used;
    logic       iss_fire, iss_rd_we, ret_valid, flush;
    logic [4:0] iss_rd_addr, ret_rd_addr;
    logic       pause;
    logic [6:0] inflight_total;
    logic       err_overflow, err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .chk_valid      (chk_valid),
        .chk_rs1_addr   (chk_rs1_addr),
        .chk_rs1_used   (chk_rs1_used),
        .chk_rs2_addr   (chk_rs2_addr),
        .chk_rs2_used   (chk_rs2_used),
        .chk_rd_addr    (chk_rd_addr),
        .chk_rd_used    (chk_rd_used),
        .iss_fire       (iss_fire),
        .iss_rd_addr    (iss_rd_addr),
        .iss_rd_we      (iss_rd_we),
        .ret_valid      (ret_valid),
        .ret_rd_addr    (ret_rd_addr),
        .flush          (flush),
        .pause          (pause),
        .inflight_total (inflight_total),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
    );

    typedef struct {
        logic       cv;
        logic [4:0] rs1; logic rs1u;
        logic [4:0] rs2; logic rs2u;
        logic [4:0] rd;  logic rdu;
        logic       iss; logic [4:0] iss_rd;
        logic       ret; logic [4:0] ret_rd;
        logic       fl;
        logic       p_nb;   // expected pause, default build
        logic       p_by;   // expected pause, bypass build
        int         tot;    // expected inflight_total after the edge
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cv,
                       input int rs1, input logic rs1u,
                       input int rs2, input logic rs2u,
                       input int rd,  input logic rdu,
                       input logic iss, input int iss_rd,
                       input logic ret, input int ret_rd,
                       input logic fl,
                       input logic p_nb, input logic p_by,
                       input int tot, input logic ovf, input logic unf);
        vec_t v;
        v.cv = cv; v.rs1 = 5'(rs1); v.rs1u = rs1u; v.rs2 = 5'(rs2); v.rs2u = rs2u;
        v.rd = 5'(rd); v.rdu = rdu; v.iss = iss; v.iss_rd = 5'(iss_rd);
        v.ret = ret; v.ret_rd = 5'(ret_rd); v.fl = fl;
        v.p_nb = p_nb; v.p_by = p_by; v.tot = tot; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        chk_valid = 0; chk_rs1_addr = 0; chk_rs1_used = 0;
        chk_rs2_addr = 0; chk_rs2_used = 0; chk_rd_addr = 0; chk_rd_used = 0;
        iss_fire = 0; iss_rd_addr = 0; iss_rd_we = 0;
        ret_valid = 0; ret_rd_addr = 0; flush = 0;
    endtask

    initial begin
        logic exp_p;
        idle_inputs();
        rst_n = 1'b0;

        //   cv rs1 u  rs2 u  rd u  iss rd  ret rd  fl  pnb pby tot ovf unf
        // Test 1: RAW on x5
        add(0, 0,0, 0,0, 0,0,  1,5,   0,0,   0,  0,0, 1, 0,0);
        add(1, 5,1, 0,0, 0,0,  0,0,   0,0,   0,  1,1, 1, 0,0);
        add(1, 5,1, 0,0, 0,0,  0,0,   1,5,   0,  1,0, 0, 0,0);
        add(1, 5,1, 0,0, 0,0,  0,0,   0,0,   0,  0,0, 0, 0,0);
        // Test 2: fill x7, WAW guard, overflow
        add(0, 0,0, 0,0, 0,0,  1,7,   0,0,   0,  0,0, 1, 0,0);
        add(1, 0,0, 7,1, 0,0,  1,7,   0,0,   0,  1,1, 2, 0,0);
        add(1, 0,0, 0,0, 7,1,  1,7,   0,0,   0,  0,0, 3, 0,0);
        add(1, 0,0, 0,0, 7,1,  0,0,   0,0,   0,  1,1, 3, 0,0);
        add(0, 7,1, 7,1, 7,1,  0,0,   0,0,   0,  0,0, 3, 0,0);
        add(1, 0,0, 0,0, 7,1,  1,7,   0,0,   0,  1,1, 3, 1,0);
        add(1, 0,0, 0,0, 7,1,  0,0,   1,7,   0,  1,0, 2, 1,0);
        // Test 3: same-cycle issue and retire of x3
        add(0, 0,0, 0,0, 0,0,  1,3,   0,0,   0,  0,0, 3, 1,0);
        add(1, 3,1, 0,0, 0,0,  1,3,   1,3,   0,  1,0, 3, 1,0);
        add(1, 3,1, 0,0, 0,0,  0,0,   0,0,   0,  1,1, 3, 1,0);
        // Test 4: x0 ignored
        add(0, 0,0, 0,0, 0,0,  1,0,   1,0,   0,  0,0, 3, 1,0);
        add(1, 0,1, 0,1, 0,1,  0,0,   0,0,   0,  0,0, 3, 1,0);
        // Test 5: flush with same-cycle issue
        add(0, 0,0, 0,0, 0,0,  1,4,   0,0,   0,  0,0, 4, 1,0);
        add(0, 0,0, 0,0, 0,0,  1,4,   0,0,   0,  0,0, 5, 1,0);
        add(0, 0,0, 0,0, 0,0,  1,9,   0,0,   0,  0,0, 6, 1,0);
        add(1, 4,1, 0,0, 0,0,  1,9,   0,0,   1,  1,1, 0, 1,0);
        add(1, 4,1, 9,1, 7,1,  0,0,   0,0,   0,  0,0, 0, 1,0);
        // Test 6: underflow, sticky through flush
        add(0, 0,0, 0,0, 0,0,  0,0,   1,12,  0,  0,0, 0, 1,1);
        add(0, 0,0, 0,0, 0,0,  0,0,   0,0,   1,  0,0, 0, 1,1);
        add(1, 12,1, 0,0, 0,0, 0,0,   0,0,   0,  0,0, 0, 1,1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_pause", pause, 0);
        check("reset_total", inflight_total, 0);
        check("reset_ovf", err_overflow, 0);
        check("reset_unf", err_underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            chk_valid    = vecs[i].cv;
            chk_rs1_addr = vecs[i].rs1; chk_rs1_used = vecs[i].rs1u;
            chk_rs2_addr = vecs[i].rs2; chk_rs2_used = vecs[i].rs2u;
            chk_rd_addr  = vecs[i].rd;  chk_rd_used  = vecs[i].rdu;
            iss_fire     = vecs[i].iss; iss_rd_addr  = vecs[i].iss_rd; iss_rd_we = vecs[i].iss;
            ret_valid    = vecs[i].ret; ret_rd_addr  = vecs[i].ret_rd;
            flush        = vecs[i].fl;
            #1;
`ifdef SCOREBOARD_BYPASS_EN
            exp_p = vecs[i].p_by;
`else
            exp_p = vecs[i].p_nb;
`endif
            check($sformatf("v%0d_pause", i), pause, exp_p);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_total", i), inflight_total, vecs[i].tot);
            check($sformatf("v%0d_ovf", i), err_overflow, vecs[i].ovf);
            check($sformatf("v%0d_unf", i), err_underflow, vecs[i].unf);
        end

        // Issue without rd_we must not count
        @(negedge clk);
        idle_inputs();
        iss_fire = 1; iss_rd_addr = 5'd8; iss_rd_we = 0;
        @(posedge clk); #1;
        check("no_we_total", inflight_total, 0);

        // Mid-operation asynchronous reset clears everything immediately
        @(negedge clk);
        idle_inputs();
        iss_fire = 1; iss_rd_addr = 5'd6; iss_rd_we = 1;
        @(posedge clk); #1;
        check("pre_rst_total", inflight_total, 1);
        @(negedge clk);
        idle_inputs();
        chk_valid = 1; chk_rs1_addr = 5'd6; chk_rs1_used = 1;
        #1;
        check("pre_rst_pause", pause, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pause", pause, 0);
        check("async_rst_total", inflight_total, 0);
        check("async_rst_ovf", err_overflow, 0);
        check("async_rst_unf", err_underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // A retire of the forgotten write now underflows
        ret_valid = 1; ret_rd_addr = 5'd6; chk_valid = 0;
        @(posedge clk); #1;
        check("post_rst_unf", err_underflow, 1);
        check("post_rst_total", inflight_total, 0);
        @(negedge clk);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
